// File: rtl/l2_cache_control.sv
// Direct-mapped 8-set L2 cache controller: owns tag/valid/dirty state, sequences hit
// service, dirty writeback and line fill, and keeps saturating hit/miss counters.
module l2_cache_control #(
  parameter int width    = 256,
  parameter int tag_bits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_address,
  input  logic [width-1:0] mem_wdata,
  output logic             mem_resp,
  output logic [width-1:0] mem_rdata,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [15:0]      pmem_address,
  output logic [width-1:0] pmem_wdata,
  input  logic             pmem_resp,
  input  logic [width-1:0] pmem_rdata,
  output logic [2:0]       array_index,
  output logic             array_write,
  output logic [width-1:0] array_datain,
  input  logic [width-1:0] array_dataout,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WB    = 2'd2,
    FILL  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [tag_bits-1:0] tag_q [8];
  logic [7:0]          valid_q, valid_d;
  logic [7:0]          dirty_q, dirty_d;
  logic [15:0]         hit_q, hit_d;
  logic [15:0]         miss_q, miss_d;
  logic                miss_flag_q, miss_flag_d;
  logic [2:0]          victim_q, victim_d;
  logic                tag_we;

  logic [2:0]          idx;
  logic [tag_bits-1:0] req_tag;
  logic                hit;
  logic                unused_offset;

  assign idx           = mem_address[7:5];
  assign req_tag       = mem_address[15 -: tag_bits];
  assign hit           = valid_q[idx] && (tag_q[idx] == req_tag);
  assign unused_offset = ^mem_address[4:0];

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      miss_flag_q <= 1'b0;
      victim_q    <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      miss_flag_q <= miss_flag_d;
      victim_q    <= victim_d;
    end
  end

  // Tags are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[idx] <= req_tag;
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    miss_flag_d  = miss_flag_q;
    victim_d     = victim_q;
    tag_we       = 1'b0;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    array_index  = '0;
    array_write  = 1'b0;
    array_datain = '0;

    // Outputs are forced low for the whole reset pulse, even mid-transfer.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          array_index = idx;
          if (mem_read || mem_write) state_d = CHECK;
        end
        CHECK: begin
          array_index = idx;
          if (!(mem_read || mem_write)) begin
            miss_flag_d = 1'b0;
            state_d     = IDLE;
          end else if (hit) begin
            mem_resp = 1'b1;
            if (mem_write) begin
              array_write  = 1'b1;
              array_datain = mem_wdata;
              dirty_d[idx] = 1'b1;
            end else begin
              mem_rdata = array_dataout;
            end
            // A hit that follows this request's own fill is not a first-pass hit.
            if (!miss_flag_q && hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
            miss_flag_d = 1'b0;
            state_d     = IDLE;
          end else begin
            if (!miss_flag_q) begin
              if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
              miss_flag_d = 1'b1;
            end
            victim_d = idx;
            state_d  = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
          end
        end
        WB: begin
          array_index  = victim_q;
          pmem_write   = 1'b1;
          pmem_address = {tag_q[victim_q], victim_q, 5'b0};
          pmem_wdata   = array_dataout;
          if (pmem_resp) begin
            dirty_d[victim_q] = 1'b0;
            state_d           = FILL;
          end
        end
        FILL: begin
          array_index  = idx;
          pmem_read    = 1'b1;
          pmem_address = {mem_address[15:5], 5'b0};
          if (pmem_resp) begin
            array_write  = 1'b1;
            array_datain = pmem_rdata;
            tag_we       = 1'b1;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            state_d      = CHECK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
- Controller for the direct-mapped, 8-set L2 cache. It sits between the L1/arbiter request port and physical memory.
- It owns tag, valid and dirty state for all sets.
- It drives the L2 data array's index, write strobe and write data, and reads back the array's combinational read data.
- It performs hit service, dirty-line writeback and line fill. It also keeps saturating hit and miss counters.

Parameters:
- width, 256, line width in bits. Matches the data array width.
- tag_bits, 8, tag width. Address is 16 bits: tag[15:8], index[7:5], offset[4:0].

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- mem_read  input  1  upstream read request, held until mem_resp
- mem_write  input  1  upstream full-line write request, held until mem_resp
- mem_address  input  16  upstream byte address; offset ignored
- mem_wdata  input  width  upstream write line
- mem_resp  output  1  one-cycle completion pulse
- mem_rdata  output  width  read line, valid while mem_resp=1
- pmem_read  output  1  physical memory read request
- pmem_write  output  1  physical memory write request
- pmem_address  output  16  line-aligned address, bits [4:0]=0
- pmem_wdata  output  width  writeback line
- pmem_resp  input  1  physical memory completion pulse
- pmem_rdata  input  width  fill line, valid with pmem_resp
- array_index  output  3  data array set index
- array_write  output  1  data array write strobe
- array_datain  output  width  data array write data
- array_dataout  input  width  data array combinational read data
- hit_count  output  16  saturating hit counter
- miss_count  output  16  saturating miss counter

Behaviour:
- Reset: asynchronous and active-high.
  - Forces state IDLE.
  - Clears valid[7:0], dirty[7:0], hit_count and miss_count.
  - Tags are don't-care.
  - All outputs are 0 while reset is asserted, including mid-writeback or mid-fill. Any pmem request drops immediately.
- array_index = mem_address[7:5] in IDLE, CHECK and FILL.
- array_index = the latched victim index in WB. It equals mem_address[7:5], since requests are held.
- States IDLE, CHECK, WB, FILL; encoded as 2 bits.
- IDLE:
  - mem_read|mem_write → CHECK next cycle.
  - No outputs are asserted.
- CHECK:
  - hit = valid[idx] && tag[idx]==mem_address[15:8].
  - Read hit: mem_resp=1 and mem_rdata=array_dataout. Increment hit_count. Go to IDLE.
  - Write hit: array_write=1 and array_datain=mem_wdata. Set dirty[idx]. mem_resp=1. Increment hit_count. Go to IDLE.
  - Miss: increment miss_count, counted only once per request (a flag is set on first miss and cleared on mem_resp). Go to WB if valid&&dirty, else FILL.
- WB:
  - pmem_write=1, pmem_address={tag[idx],idx,5'b0}, pmem_wdata=array_dataout. Held stable until pmem_resp.
  - On pmem_resp: clear dirty[idx] and go to FILL.
- FILL:
  - pmem_read=1, pmem_address={mem_address[15:5],5'b0}.
  - On pmem_resp: array_write=1, array_datain=pmem_rdata. Tag is updated, valid[idx]=1, dirty[idx]=0. Go to CHECK, which then hits.
  - The hit after a fill does not increment hit_count; only first-pass hits count.
- Latency:
  - Hit: mem_resp 2 cycles after the request appears in IDLE.
  - Clean miss: 2 + fill latency + 1 cycles.
  - Dirty miss: additionally the writeback latency.
- pmem_read and pmem_write are never asserted simultaneously.
- mem_resp is never asserted outside CHECK.
- Both mem_read and mem_write high is illegal upstream; the controller treats it as a write.
- Counters saturate at 16'hFFFF with no wrap.
- A pmem_resp arriving in IDLE or CHECK is ignored.
- Implementation target: 150–250 lines.

Test Plan:
- After reset, read 16'h1240 (idx 2). Required: miss, then FILL with pmem_address=16'h1240. Return pmem_rdata=256'hA5… → mem_resp with mem_rdata=256'hA5…. miss_count=1, hit_count=0.
- Read 16'h1240 again. Required: mem_resp exactly 2 cycles after request, no pmem activity, hit_count=1.
- Write 16'h1240 with data D1, then read 16'h2240 (same idx 2, tag 8'h22). Required: WB with pmem_address=16'h1240 and pmem_wdata=D1 first, then FILL at 16'h2240. miss_count=2.
- Write-miss to clean set 16'h00E0 (idx 7). Required: FILL only (no WB), then array_write with mem_wdata, dirty[7]=1, one mem_resp.
- Assert reset during WB with pmem_resp withheld. Required: pmem_write=0 immediately. The next access to any address misses with no writeback, and counters read 0.
- Hold pmem_resp low for 20 cycles during FILL. Required: pmem_read and pmem_address stay stable, mem_resp=0 throughout, and miss_count increments once.
